branch_hist_queue: RTL and testbench

BRANCH_HIST_QUEUE -- requirements
Module: branch_hist_queue

---
 rtl/branch_hist_queue_pkg.sv | 10 +
 rtl/branch_hist_queue_if.sv | 26 ++
 rtl/branch_hist_queue.sv | 109 ++++++++++
 tb/tb_branch_hist_queue.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_hist_queue_pkg.sv
// Shared front-end types: fetch address and the resolved-branch record from execute.
package branch_hist_queue_pkg;
    typedef logic [31:0] Addr;

    typedef struct packed {
        logic valid;
        Addr  pc;
        logic taken;
    } BrInfo;
endpackage

// File: rtl/branch_hist_queue_if.sv
// Fetch/execute/predictor signal bundle for the branch history queue.
interface branch_hist_queue_if #(parameter int WIDTH_HIST = 10);
    import branch_hist_queue_pkg::*;

    logic                  push_valid;
    Addr                   push_pc;
    logic                  pred_taken;
    logic                  push_ready;
    logic [WIDTH_HIST-1:0] spec_hist;
    BrInfo                 brinfo;
    logic                  upd_valid;
    logic                  upd_taken;
    logic [WIDTH_HIST-1:0] upd_hist;
    logic                  mispredict;
    logic                  err;

    modport master (
        output push_valid, push_pc, pred_taken, brinfo,
        input  push_ready, spec_hist, upd_valid, upd_taken, upd_hist, mispredict, err
    );

    modport slave (
        input  push_valid, push_pc, pred_taken, brinfo,
        output push_ready, spec_hist, upd_valid, upd_taken, upd_hist, mispredict, err
    );
endinterface

// File: rtl/branch_hist_queue.sv
// In-order queue of predicted branches holding the history snapshot each was fetched with;
// owns the speculative global history and repairs it on a mispredicted resolve.
module branch_hist_queue
    import branch_hist_queue_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int WIDTH_HIST = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    branch_hist_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        Addr                   pc;
        logic [WIDTH_HIST-1:0] hist;
        logic                  pred;
    } entry_t;

    entry_t                mem_q [DEPTH];
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [WIDTH_HIST-1:0] spec_hist_q, spec_hist_d;
    logic [WIDTH_HIST-1:0] upd_hist_q, upd_hist_d;
    logic                  upd_valid_q, upd_valid_d;
    logic                  upd_taken_q, upd_taken_d;
    logic                  mispredict_q, mispredict_d;
    logic                  err_q, err_d;

    entry_t head;
    logic   empty, full, pop, mis, push_acc;

    assign head     = mem_q[head_q];
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign pop      = bus.brinfo.valid && !empty;
    assign mis      = pop && (bus.brinfo.taken != head.pred);
    // Push acceptance looks at pre-pop fullness: no bypass through a same-cycle pop.
    assign push_acc = bus.push_valid && !full && !mis;

    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        spec_hist_d  = spec_hist_q;
        upd_valid_d  = pop;
        upd_taken_d  = upd_taken_q;
        upd_hist_d   = upd_hist_q;
        mispredict_d = mis;
        err_d        = err_q;

        if (bus.brinfo.valid && empty) err_d = 1'b1;
        if (pop) begin
            upd_taken_d = bus.brinfo.taken;
            upd_hist_d  = head.hist;
            if (bus.brinfo.pc != head.pc) err_d = 1'b1;
        end

        if (mis) begin
            // Everything younger than the head was fetched down the wrong path.
            head_d      = tail_q;
            count_d     = '0;
            spec_hist_d = {head.hist[WIDTH_HIST-2:0], bus.brinfo.taken};
        end else begin
            head_d  = head_q + PTR_W'(pop);
            tail_d  = tail_q + PTR_W'(push_acc);
            count_d = count_q + CNT_W'(push_acc) - CNT_W'(pop);
            if (push_acc) spec_hist_d = {spec_hist_q[WIDTH_HIST-2:0], bus.pred_taken};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            spec_hist_q  <= '0;
            upd_valid_q  <= 1'b0;
            upd_taken_q  <= 1'b0;
            upd_hist_q   <= '0;
            mispredict_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            spec_hist_q  <= spec_hist_d;
            upd_valid_q  <= upd_valid_d;
            upd_taken_q  <= upd_taken_d;
            upd_hist_q   <= upd_hist_d;
            mispredict_q <= mispredict_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) mem_q[tail_q] <= '{pc: bus.push_pc, hist: spec_hist_q, pred: bus.pred_taken};
    end

    assign bus.push_ready = !full;
    assign bus.spec_hist  = spec_hist_q;
    assign bus.upd_valid  = upd_valid_q;
    assign bus.upd_taken  = upd_taken_q;
    assign bus.upd_hist   = upd_hist_q;
    assign bus.mispredict = mispredict_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_branch_hist_queue.sv
// Bench for branch_hist_queue: directed scenarios plus random traffic against a queue-based model.
module tb_branch_hist_queue;
    import branch_hist_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int WH    = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    branch_hist_queue_if #(.WIDTH_HIST(WH)) bif ();
    branch_hist_queue #(.DEPTH(DEPTH), .WIDTH_HIST(WH)) dut (.clk(clk), .rst_n(rst_n), .bus(bif.slave));

    typedef struct {
        Addr           pc;
        logic [WH-1:0] hist;
        logic          pred;
    } ent_t;

    ent_t          m_q[$];
    logic [WH-1:0] exp_spec, exp_hist;
    logic          exp_uv, exp_ut, exp_mis, exp_err;
    int            errors = 0;
    int            checks = 0;

    task automatic model_clear();
        m_q.delete();
        exp_spec = '0; exp_hist = '0;
        exp_uv = 0; exp_ut = 0; exp_mis = 0; exp_err = 0;
    endtask

    task automatic idle_inputs();
        bif.push_valid = 0; bif.push_pc = '0; bif.pred_taken = 0; bif.brinfo = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        model_clear();
    endtask

    // Applies one cycle of stimulus and advances the model by the queue's rules.
    task automatic drive_cycle(input logic pv, input Addr pc, input logic pt,
                               input logic bv, input Addr bpc, input logic bt);
        logic pop, mis, acc;
        bif.push_valid = pv; bif.push_pc = pc; bif.pred_taken = pt;
        bif.brinfo.valid = bv; bif.brinfo.pc = bpc; bif.brinfo.taken = bt;
        pop = bv && (m_q.size() != 0);
        mis = 0;
        if (pop) mis = (bt != m_q[0].pred);
        acc = pv && (m_q.size() < DEPTH) && !mis;
        exp_uv = pop; exp_mis = mis;
        if (bv && !pop) exp_err = 1;
        if (pop) begin
            exp_ut = bt; exp_hist = m_q[0].hist;
            if (bpc != m_q[0].pc) exp_err = 1;
        end
        if (mis) begin
            exp_spec = {m_q[0].hist[WH-2:0], bt};
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (acc) begin
                m_q.push_back('{pc: pc, hist: exp_spec, pred: pt});
                exp_spec = {exp_spec[WH-2:0], pt};
            end
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 rst_n = 0;
        #2;
        checks++;
        if ({bif.upd_valid, bif.upd_taken, bif.upd_hist, bif.mispredict, bif.err, bif.spec_hist} !== '0) begin
            errors++; $display("FAIL reset_outputs: got uv=%b ut=%b uh=%h mis=%b err=%b sh=%h, want all 0",
                               bif.upd_valid, bif.upd_taken, bif.upd_hist, bif.mispredict, bif.err, bif.spec_hist);
        end
        checks++;
        if (bif.push_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bif.push_ready); end
        @(posedge clk); #1;
        rst_n = 1;
        model_clear();
    endtask

    task automatic test_basic();
        do_reset();
        drive_cycle(1, 32'h100, 1, 0, '0, 0);
        checks++;
        if (bif.spec_hist !== 10'h001) begin errors++; $display("FAIL basic_spec_push: got %h want 001", bif.spec_hist); end
        drive_cycle(0, '0, 0, 1, 32'h100, 1);
        checks++;
        if ({bif.upd_valid, bif.upd_taken, bif.mispredict} !== 3'b110) begin
            errors++; $display("FAIL basic_update: got uv=%b ut=%b mis=%b want 1 1 0", bif.upd_valid, bif.upd_taken, bif.mispredict);
        end
        checks++;
        if (bif.upd_hist !== 10'h000) begin errors++; $display("FAIL basic_upd_hist: got %h want 000", bif.upd_hist); end
        checks++;
        if (bif.spec_hist !== 10'h001) begin errors++; $display("FAIL basic_spec_after: got %h want 001", bif.spec_hist); end
        drive_cycle(0, '0, 0, 0, '0, 0);
        checks++;
        if (bif.upd_valid !== 1'b0) begin errors++; $display("FAIL basic_upd_one_cycle: got %b want 0", bif.upd_valid); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) drive_cycle(1, 32'(32'h1000 + i*4), i[0], 0, '0, 0);
        checks++;
        if (bif.push_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", bif.push_ready); end
        drive_cycle(1, 32'hDEAD, 1, 0, '0, 0);
        checks++;
        if (bif.push_ready !== 1'b0 || bif.spec_hist !== exp_spec) begin
            errors++; $display("FAIL full_ninth_push: got ready=%b sh=%h want 0 %h", bif.push_ready, bif.spec_hist, exp_spec);
        end
        // Correct resolve with a push while full: only the pop happens.
        drive_cycle(1, 32'hBEEF, 1, 1, 32'h1000, 0);
        checks++;
        if (bif.upd_valid !== 1'b1 || bif.mispredict !== 1'b0 || bif.push_ready !== 1'b1) begin
            errors++; $display("FAIL full_pop_push: got uv=%b mis=%b ready=%b want 1 0 1", bif.upd_valid, bif.mispredict, bif.push_ready);
        end
        for (int i = 1; i < DEPTH; i++) begin
            drive_cycle(0, '0, 0, 1, 32'(32'h1000 + i*4), i[0]);
            checks++;
            if (bif.upd_valid !== 1'b1 || bif.upd_hist !== exp_hist || bif.err !== 1'b0) begin
                errors++; $display("FAIL full_drain_%0d: got uv=%b uh=%h err=%b want 1 %h 0", i, bif.upd_valid, bif.upd_hist, bif.err, exp_hist);
            end
        end
        drive_cycle(0, '0, 0, 1, 32'hBEEF, 1);
        checks++;
        if (bif.upd_valid !== 1'b0 || bif.err !== 1'b1) begin
            errors++; $display("FAIL full_no_extra: got uv=%b err=%b want 0 1", bif.upd_valid, bif.err);
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1, 32'(32'h300 + i*4), 1, 0, '0, 0);
        checks++;
        if (bif.spec_hist !== 10'h007) begin errors++; $display("FAIL mis_spec_pushes: got %h want 007", bif.spec_hist); end
        drive_cycle(0, '0, 0, 1, 32'h300, 0);
        checks++;
        if (bif.mispredict !== 1'b1 || bif.upd_valid !== 1'b1 || bif.spec_hist !== 10'h000) begin
            errors++; $display("FAIL mis_repair: got mis=%b uv=%b sh=%h want 1 1 000", bif.mispredict, bif.upd_valid, bif.spec_hist);
        end
        drive_cycle(0, '0, 0, 1, 32'h304, 1);
        checks++;
        if (bif.upd_valid !== 1'b0 || bif.err !== 1'b1 || bif.mispredict !== 1'b0) begin
            errors++; $display("FAIL mis_emptied: got uv=%b err=%b mis=%b want 0 1 0", bif.upd_valid, bif.err, bif.mispredict);
        end
    endtask

    task automatic test_push_mispredict();
        do_reset();
        drive_cycle(1, 32'h400, 0, 0, '0, 0);
        drive_cycle(1, 32'h404, 1, 1, 32'h400, 1);
        checks++;
        if (bif.mispredict !== 1'b1 || bif.spec_hist !== 10'h001 || bif.push_ready !== 1'b1) begin
            errors++; $display("FAIL pm_repair: got mis=%b sh=%h ready=%b want 1 001 1", bif.mispredict, bif.spec_hist, bif.push_ready);
        end
        drive_cycle(0, '0, 0, 1, 32'h404, 1);
        checks++;
        if (bif.upd_valid !== 1'b0 || bif.err !== 1'b1) begin
            errors++; $display("FAIL pm_push_dropped: got uv=%b err=%b want 0 1", bif.upd_valid, bif.err);
        end
    endtask

    task automatic test_err();
        do_reset();
        drive_cycle(0, '0, 0, 1, 32'h500, 1);
        checks++;
        if (bif.upd_valid !== 1'b0 || bif.err !== 1'b1) begin
            errors++; $display("FAIL err_empty: got uv=%b err=%b want 0 1", bif.upd_valid, bif.err);
        end
        do_reset();
        drive_cycle(1, 32'h500, 1, 0, '0, 0);
        drive_cycle(0, '0, 0, 1, 32'h504, 1);
        checks++;
        if (bif.upd_valid !== 1'b1 || bif.err !== 1'b1 || bif.mispredict !== 1'b0) begin
            errors++; $display("FAIL err_pc_mismatch: got uv=%b err=%b mis=%b want 1 1 0", bif.upd_valid, bif.err, bif.mispredict);
        end
        drive_cycle(0, '0, 0, 1, 32'h500, 1);
        checks++;
        if (bif.upd_valid !== 1'b0) begin errors++; $display("FAIL err_popped: got uv=%b want 0", bif.upd_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) drive_cycle(1, 32'(32'h600 + i*4), i[1], 0, '0, 0);
        drive_cycle(0, '0, 0, 1, 32'h600, 0);
        #2 rst_n = 0;
        #1;
        checks++;
        if ({bif.upd_valid, bif.upd_taken, bif.upd_hist, bif.mispredict, bif.err, bif.spec_hist} !== '0
            || bif.push_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_outputs: got uv=%b uh=%h mis=%b err=%b sh=%h ready=%b want zeros ready=1",
                               bif.upd_valid, bif.upd_hist, bif.mispredict, bif.err, bif.spec_hist, bif.push_ready);
        end
        @(posedge clk); #1;
        rst_n = 1;
        model_clear();
        drive_cycle(0, '0, 0, 1, 32'h604, 0);
        checks++;
        if (bif.upd_valid !== 1'b0 || bif.err !== 1'b1) begin
            errors++; $display("FAIL midreset_dropped: got uv=%b err=%b want 0 1", bif.upd_valid, bif.err);
        end
    endtask

    task automatic test_random();
        logic pv, pt, bv, bt;
        Addr  pc, bpc;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            pv  = ($urandom_range(0, 99) < 60);
            pt  = $urandom_range(0, 1);
            pc  = $urandom & 32'hFFFF_FFFC;
            bv  = ($urandom_range(0, 99) < 40);
            bpc = (m_q.size() != 0) ? m_q[0].pc : 32'h0;
            bt  = (m_q.size() != 0) ? m_q[0].pred : 1'b0;
            if ($urandom_range(0, 99) < 15) bt = ~bt;
            if ($urandom_range(0, 99) < 3)  bpc = bpc ^ 32'h4;
            drive_cycle(pv, pc, pt, bv, bpc, bt);
            checks++;
            if (bif.upd_valid !== exp_uv || bif.mispredict !== exp_mis || bif.err !== exp_err
                || bif.spec_hist !== exp_spec || bif.push_ready !== (m_q.size() < DEPTH)
                || (exp_uv && (bif.upd_hist !== exp_hist || bif.upd_taken !== exp_ut))) begin
                errors++;
                $display("FAIL random_%0d: got uv=%b mis=%b err=%b sh=%h rdy=%b uh=%h ut=%b want %b %b %b %h %b %h %b",
                         n, bif.upd_valid, bif.mispredict, bif.err, bif.spec_hist, bif.push_ready, bif.upd_hist, bif.upd_taken,
                         exp_uv, exp_mis, exp_err, exp_spec, (m_q.size() < DEPTH), exp_hist, exp_ut);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_mispredict();
        test_push_mispredict();
        test_err();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
